ascon_output_deserializer: RTL and testbench

Downstream stage of the bit-serial Ascon top level. It collects the serial ciphertext/plaintext stream (output_dataxSI) and tag stream (tagxSI) emitted after the core's ready strobe, and rebuilds them as parallel words. It optionally compares the rebuilt tag against an expected tag for decrypt-side authentication. Results are held for a consumer until a valid/ack handshake completes.

---
 rtl/ascon_output_deserializer.sv | 140 ++++++++++++++
 tb/tb_ascon_output_deserializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_output_deserializer.sv
// Rebuilds the bit-serial Ascon data and tag streams into parallel words.
// A rising edge on the core ready strobe starts a fixed 128-cycle capture.
// The result is held until the consumer acknowledges it. When check_en was
// set at capture start, the rebuilt tag is also compared with expected_tag.
module ascon_output_deserializer #(
  parameter int y = 32,
  parameter int t = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ascon_readyxSI,
  input  logic         output_dataxSI,
  input  logic         tagxSI,
  input  logic         check_en,
  input  logic [127:0] expected_tag,
  output logic [y-1:0] data_out,
  output logic [127:0] tag_out,
  output logic         out_valid,
  input  logic         out_ack,
  output logic         tag_match,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Number of data samples kept, and the count value of the final capture cycle.
  localparam logic [7:0] DATA_LEN = 8'(y);
  localparam logic [7:0] LAST_CNT = 8'(t - 1);

  state_t         state;
  state_t         state_next;
  logic           ready_d;
  logic [7:0]     cnt;
  logic [y-1:0]   data_sr;
  logic [127:0]   tag_sr;
  logic           check_reg;

  logic           start;
  logic           last_sample;
  logic           data_active;
  logic [y-1:0]   data_shift;
  logic [127:0]   tag_shift;

  assign start       = ascon_readyxSI && !ready_d;
  assign last_sample = (state == CAPTURE) && (cnt == LAST_CNT);
  assign data_active = (cnt < DATA_LEN);
  // Shift values that include the bit being sampled this cycle, so the
  // final sample reaches the outputs on the same edge that leaves CAPTURE.
  assign data_shift  = {output_dataxSI, data_sr[y-1:1]};
  assign tag_shift   = {tagxSI, tag_sr[127:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        if (last_sample) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ready edge detector: sampled every cycle, whatever the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_d <= 1'b0;
    end else begin
      ready_d <= ascon_readyxSI;
    end
  end

  // Sample counter, shift registers and the check-enable latched at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 8'd0;
      data_sr   <= '0;
      tag_sr    <= '0;
      check_reg <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cnt       <= 8'd0;
        check_reg <= check_en;
      end else if (state == CAPTURE) begin
        if (data_active) begin
          data_sr <= data_shift;
        end
        tag_sr <= tag_shift;
        if (!last_sample) begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Result registers: loaded only when a capture completes, so they never
  // show partial words and keep their values after the acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      tag_out   <= '0;
      tag_match <= 1'b0;
    end else if (last_sample) begin
      data_out  <= data_active ? data_shift : data_sr;
      tag_out   <= tag_shift;
      tag_match <= check_reg ? (tag_shift == expected_tag) : 1'b1;
    end
  end

endmodule

// File: tb/tb_ascon_output_deserializer.sv
// Directed bench for ascon_output_deserializer with y=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ascon_output_deserializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         ascon_readyxSI;
  logic         output_dataxSI;
  logic         tagxSI;
  logic         check_en;
  logic [127:0] expected_tag;
  logic [31:0]  data_out;
  logic [127:0] tag_out;
  logic         out_valid;
  logic         out_ack;
  logic         tag_match;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] TAG_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] TAG_B = 128'h00112233445566778899AABBCCDDEEFF;

  ascon_output_deserializer #(.y(32), .t(128)) dut (
    .clk            (clk),
    .rst            (rst),
    .ascon_readyxSI (ascon_readyxSI),
    .output_dataxSI (output_dataxSI),
    .tagxSI         (tagxSI),
    .check_en       (check_en),
    .expected_tag   (expected_tag),
    .data_out       (data_out),
    .tag_out        (tag_out),
    .out_valid      (out_valid),
    .out_ack        (out_ack),
    .tag_match      (tag_match),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Drives one capture. drop_first puts ready low for one cycle first.
  // pulse_at>=0 adds an extra ready low/high pulse during the capture.
  // abort_at>=0 asserts reset at that bit and returns early.
  task automatic run_capture(input logic [31:0] d, input logic [127:0] tg,
                             input logic ce, input logic [127:0] et,
                             input logic drop_first, input int pulse_at,
                             input int abort_at);
    if (drop_first) begin
      @(negedge clk);
      ascon_readyxSI = 1'b0;
    end
    @(negedge clk);
    ascon_readyxSI = 1'b1;
    check_en       = ce;
    expected_tag   = et;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (j == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_at_start got %b want 1", busy);
        end
      end
      if (j == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 32'h0 || tag_out !== 128'h0 || out_valid !== 1'b0 ||
            tag_match !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_capture got data=%h tag=%h v=%b m=%b b=%b want all 0",
                   data_out, tag_out, out_valid, tag_match, busy);
        end
        @(negedge clk);
        rst            = 1'b0;
        ascon_readyxSI = 1'b0;
        return;
      end
      if (j == pulse_at - 1) ascon_readyxSI = 1'b0;
      if (j == pulse_at)     ascon_readyxSI = 1'b1;
      output_dataxSI = (j < 32) ? d[j] : 1'($urandom_range(0, 1));
      tagxSI         = tg[j];
      if (j == 127) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid got %b want 0 at cycle 128", out_valid);
        end
      end
    end
    @(negedge clk);
    output_dataxSI = 1'b0;
    tagxSI         = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_valid got v=%b b=%b want v=1 b=0 at cycle 129", out_valid, busy);
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] d,
                              input logic [127:0] tg, input logic m);
    checks++;
    if (data_out !== d) begin
      errors++;
      $display("FAIL %s_data got %h want %h", name, data_out, d);
    end
    checks++;
    if (tag_out !== tg) begin
      errors++;
      $display("FAIL %s_tag got %h want %h", name, tag_out, tg);
    end
    checks++;
    if (tag_match !== m) begin
      errors++;
      $display("FAIL %s_match got %b want %b", name, tag_match, m);
    end
    $display("%s: data=%h tag=%h match=%b", name, data_out, tag_out, tag_match);
  endtask

  task automatic do_ack(input logic [31:0] d);
    @(negedge clk);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== d) begin
      errors++;
      $display("FAIL ack_release got v=%b b=%b data=%h want v=0 b=0 data=%h",
               out_valid, busy, data_out, d);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ascon_readyxSI = 1'b0; output_dataxSI = 1'b0; tagxSI = 1'b0;
    check_en = 1'b0; expected_tag = '0; out_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== 32'h0 || tag_out !== 128'h0 || out_valid !== 1'b0 ||
        tag_match !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got data=%h tag=%h v=%b m=%b b=%b want all 0",
               data_out, tag_out, out_valid, tag_match, busy);
    end
    rst = 1'b0;
    // Acknowledge while idle must do nothing.
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack got v=%b b=%b want 0 0", out_valid, busy);
    end
    $display("reset: done");
  endtask

  task automatic test_encrypt;
    run_capture(32'hDEADBEEF, TAG_A, 1'b0, TAG_B, 1'b1, -1, -1);
    check_result("encrypt", 32'hDEADBEEF, TAG_A, 1'b1);
    do_ack(32'hDEADBEEF);
  endtask

  task automatic test_decrypt;
    logic [127:0] bad;
    bad = TAG_A ^ (128'h1 << 77);
    run_capture(32'h12345678, TAG_A, 1'b1, TAG_A, 1'b1, -1, -1);
    check_result("decrypt_match", 32'h12345678, TAG_A, 1'b1);
    do_ack(32'h12345678);
    run_capture(32'h12345678, TAG_A, 1'b1, bad, 1'b1, -1, -1);
    check_result("decrypt_bad", 32'h12345678, TAG_A, 1'b0);
    do_ack(32'h12345678);
  endtask

  task automatic test_handshake_hold;
    run_capture(32'hCAFEF00D, TAG_B, 1'b0, TAG_A, 1'b1, -1, -1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || data_out !== 32'hCAFEF00D || tag_out !== TAG_B) begin
        errors++;
        $display("FAIL hold_%0d got v=%b data=%h want v=1 data=cafef00d",
                 k, out_valid, data_out);
      end
    end
    $display("hold: 50 cycles checked");
    do_ack(32'hCAFEF00D);
  endtask

  task automatic test_rearm;
    // Ready stays high through DONE, the ack and beyond.
    run_capture(32'h0BADC0DE, TAG_A, 1'b0, TAG_A, 1'b1, -1, -1);
    do_ack(32'h0BADC0DE);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rearm_level got b=%b v=%b want 0 0", busy, out_valid);
    end
    run_capture(32'h00000001, TAG_B, 1'b0, TAG_A, 1'b1, -1, -1);
    check_result("rearm", 32'h00000001, TAG_B, 1'b1);
    do_ack(32'h00000001);
  endtask

  task automatic test_reset_mid;
    run_capture(32'hFFFFFFFF, TAG_A, 1'b0, TAG_A, 1'b1, -1, 59);
    run_capture(32'hA5A5A5A5, TAG_B, 1'b1, TAG_B, 1'b1, -1, -1);
    check_result("after_reset", 32'hA5A5A5A5, TAG_B, 1'b1);
    do_ack(32'hA5A5A5A5);
  endtask

  task automatic test_edge_during_capture;
    run_capture(32'h5EED1234, TAG_A, 1'b0, TAG_A, 1'b1, 40, -1);
    check_result("edge_ignored", 32'h5EED1234, TAG_A, 1'b1);
    do_ack(32'h5EED1234);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL edge_not_queued got b=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_handshake_hold();
    test_rearm();
    test_reset_mid();
    test_edge_during_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
